// File: rtl/fp_add_pipe_if.sv
// ============================================================================
// Module      : fp_add_pipe_if
// Description : Operand/result stream bundle for the pipelined FP adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

`default_nettype wire

// File: rtl/fp_add_pipe.sv
// ============================================================================
// Module      : fp_add_pipe
// Description : 3-stage IEEE-754-style adder/subtractor, RNE, flush-to-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fp_add_pipe_if.slave   bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;
    localparam int EW   = EXP_W + 2;
    localparam int LZ_W = $clog2(MW + 1);
    localparam logic signed [EW-1:0] c_EXP_MAX = EW'((2 ** EXP_W) - 1);
    localparam logic [1:0] c_KIND_NORM = 2'd0;
    localparam logic [1:0] c_KIND_NAN  = 2'd1;
    localparam logic [1:0] c_KIND_INF  = 2'd2;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic             w_sa, w_sb, w_a_zero, w_b_zero, w_a_big;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_nan, w_inf;
    logic [EXP_W-1:0] w_ea, w_eb, w_exp_l, w_exp_s, w_diff;
    logic [MAN_W:0]   w_ma, w_mb, w_ml, w_ms;
    logic [W-2:0]     w_key_a, w_key_b;
    logic [31:0]      w_shamt;
    logic [2*MW-1:0]  w_wide;
    logic [MW-1:0]    w_aligned;

    assign w_sa     = bus.in_a[W-1];
    assign w_sb     = bus.in_b[W-1] ^ bus.in_sub;
    assign w_ea     = bus.in_a[W-2:MAN_W];
    assign w_eb     = bus.in_b[W-2:MAN_W];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_nan_a  = (&w_ea) & (|bus.in_a[MAN_W-1:0]);
    assign w_nan_b  = (&w_eb) & (|bus.in_b[MAN_W-1:0]);
    assign w_inf_a  = (&w_ea) & ~(|bus.in_a[MAN_W-1:0]);
    assign w_inf_b  = (&w_eb) & ~(|bus.in_b[MAN_W-1:0]);
    assign w_nan    = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sa ^ w_sb));
    assign w_inf    = w_inf_a | w_inf_b;

    // Subnormal inputs are flushed: mantissa and magnitude key forced to zero
    assign w_ma    = w_a_zero ? '0 : {1'b1, bus.in_a[MAN_W-1:0]};
    assign w_mb    = w_b_zero ? '0 : {1'b1, bus.in_b[MAN_W-1:0]};
    assign w_key_a = w_a_zero ? '0 : bus.in_a[W-2:0];
    assign w_key_b = w_b_zero ? '0 : bus.in_b[W-2:0];
    assign w_a_big = (w_key_a >= w_key_b);
    assign w_exp_l = w_a_big ? w_ea : w_eb;
    assign w_exp_s = w_a_big ? w_eb : w_ea;
    assign w_ml    = w_a_big ? w_ma : w_mb;
    assign w_ms    = w_a_big ? w_mb : w_ma;
    assign w_diff  = w_exp_l - w_exp_s;

    // Clamping at MW still pushes every bit into the sticky half
    always_comb begin
        w_shamt = 32'(w_diff);
        if (w_shamt > 32'(MW)) begin
            w_shamt = 32'(MW);
        end
        w_wide = {w_ms, 3'b000, {MW{1'b0}}} >> w_shamt;
    end
    assign w_aligned = {w_wide[2*MW-1:MW+1], w_wide[MW] | (|w_wide[MW-1:0])};

    logic             r1_valid, r1_sign, r1_sub, r1_zero_sign, r1_spec_sign;
    logic [1:0]       r1_kind;
    logic [EXP_W-1:0] r1_exp_l;
    logic [MAN_W:0]   r1_mant_l;
    logic [MW-1:0]    r1_mant_s;

    // ---------------- S2: add/sub, leading-one detect, normalise ----------------
    logic [MW:0]            w_sum;
    logic [LZ_W-1:0]        w_lz;
    logic [MW-1:0]          w_norm;
    logic signed [EW-1:0]   w_exp_n;

    assign w_sum = r1_sub ? ({1'b0, r1_mant_l, 3'b000} - {1'b0, r1_mant_s})
                          : ({1'b0, r1_mant_l, 3'b000} + {1'b0, r1_mant_s});

    always_comb begin
        w_lz = LZ_W'(MW);
        for (int i = 0; i < MW; i++) begin
            if (w_sum[i]) begin
                w_lz = LZ_W'(MW - 1 - i);
            end
        end
    end

    always_comb begin
        if (w_sum[MW]) begin
            w_norm  = {w_sum[MW:2], |w_sum[1:0]};
            w_exp_n = EW'(r1_exp_l) + EW'(1);
        end else begin
            w_norm  = w_sum[MW-1:0] << w_lz;
            w_exp_n = EW'(r1_exp_l) - EW'(w_lz);
        end
    end

    logic                 r2_valid, r2_sign, r2_zero, r2_zero_sign, r2_spec_sign;
    logic [1:0]           r2_kind;
    logic signed [EW-1:0] r2_exp;
    logic [MW-1:0]        r2_mant;

    // ---------------- S3: round, renormalise, pack, exceptions ----------------
    logic                 w_inexact, w_up;
    logic [MAN_W+1:0]     w_rnd;
    logic [MAN_W-1:0]     w_frac;
    logic signed [EW-1:0] w_exp_r;
    logic [W-1:0]         w_res;
    logic [3:0]           w_flags;

    assign w_inexact = |r2_mant[2:0];
    assign w_up      = r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
    assign w_rnd     = {1'b0, r2_mant[MW-1:3]} + (MAN_W+2)'(w_up);
    assign w_frac    = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_exp_r   = r2_exp + EW'(w_rnd[MAN_W+1]);

    always_comb begin
        w_res   = {r2_sign, w_exp_r[EXP_W-1:0], w_frac};
        w_flags = {3'b000, w_inexact};
        if (r2_kind == c_KIND_NAN) begin
            w_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags = 4'b1000;
        end else if (r2_kind == c_KIND_INF) begin
            w_res   = {r2_spec_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 4'b0000;
        end else if (r2_zero) begin
            w_res   = {r2_zero_sign, {(W-1){1'b0}}};
            w_flags = 4'b0000;
        end else if (w_exp_r >= c_EXP_MAX) begin
            w_res   = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 4'b0101;
        end else if (w_exp_r <= 0) begin
            w_res   = {r2_sign, {(W-1){1'b0}}};
            w_flags = 4'b0011;
        end
    end

    logic         r3_valid;
    logic [W-1:0] r3_result;
    logic [3:0]   r3_flags;
    logic         w_stall;

    assign w_stall        = r3_valid & ~bus.out_ready;
    assign bus.in_ready   = ~w_stall;
    assign bus.out_valid  = r3_valid;
    assign bus.out_result = r3_result;
    assign bus.out_flags  = r3_flags;

    // Whole pipeline advances together; data registers load only behind a valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid     <= 1'b0;
            r1_sign      <= 1'b0;
            r1_sub       <= 1'b0;
            r1_zero_sign <= 1'b0;
            r1_spec_sign <= 1'b0;
            r1_kind      <= c_KIND_NORM;
            r1_exp_l     <= '0;
            r1_mant_l    <= '0;
            r1_mant_s    <= '0;
            r2_valid     <= 1'b0;
            r2_sign      <= 1'b0;
            r2_zero      <= 1'b0;
            r2_zero_sign <= 1'b0;
            r2_spec_sign <= 1'b0;
            r2_kind      <= c_KIND_NORM;
            r2_exp       <= '0;
            r2_mant      <= '0;
            r3_valid     <= 1'b0;
            r3_result    <= '0;
            r3_flags     <= '0;
        end else if (!w_stall) begin
            r1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1_sign      <= w_a_big ? w_sa : w_sb;
                r1_sub       <= w_sa ^ w_sb;
                r1_zero_sign <= w_sa & w_sb;
                r1_spec_sign <= w_inf_a ? w_sa : w_sb;
                r1_kind      <= w_nan ? c_KIND_NAN : (w_inf ? c_KIND_INF : c_KIND_NORM);
                r1_exp_l     <= w_exp_l;
                r1_mant_l    <= w_ml;
                r1_mant_s    <= w_aligned;
            end
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign      <= r1_sign;
                r2_zero      <= (w_sum == '0);
                r2_zero_sign <= r1_zero_sign;
                r2_spec_sign <= r1_spec_sign;
                r2_kind      <= r1_kind;
                r2_exp       <= w_exp_n;
                r2_mant      <= w_norm;
            end
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_result <= w_res;
                r3_flags  <= w_flags;
            end
        end
    end
endmodule

`default_nettype wire
